// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: MMIO map, STATUS bit layout and FIFO count sizing.
package dmem_responder_pkg;
  localparam logic [1:0] OFF_CYCLE = 2'd0;
  localparam logic [1:0] OFF_TXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_COUNT = 8;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_F000;
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: processor data-memory port plus TX stream to the consumer.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  modport master(output address_dmem, data, wren, tx_ready, input q_dmem, tx_data, tx_valid);
  modport slave(input address_dmem, data, wren, tx_ready, output q_dmem, tx_data, tx_valid);
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// dmem_responder_tx_fifo: 32-bit TX FIFO; a push into a full FIFO only lands alongside a pop.
module dmem_responder_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clock)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus CYCLE/TXDATA/STATUS registers behind the data-memory port.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int CW = count_width(FIFO_DEPTH);
  logic [31:0] ram [2**ADDR_WIDTH];
  logic [31:0] cycle, off, status;
  logic in_ram, in_mmio, wr_cycle, push, clr, pop, full, empty, ovf;
  logic [CW-1:0] count;
  assign off = bus.address_dmem - MMIO_BASE;
  assign in_ram = (bus.address_dmem >> ADDR_WIDTH) == '0;
  assign in_mmio = ~in_ram & (off < 32'd4);
  assign wr_cycle = bus.wren & in_mmio & (off[1:0] == OFF_CYCLE);
  assign push = bus.wren & in_mmio & (off[1:0] == OFF_TXDATA);
  assign clr = bus.wren & in_mmio & (off[1:0] == OFF_STATUS) & bus.data[ST_OVF];
  assign pop = bus.tx_valid & bus.tx_ready;
  assign bus.tx_valid = ~empty;
  always_ff @(posedge clock)
    if (bus.wren & in_ram) ram[bus.address_dmem[ADDR_WIDTH-1:0]] <= bus.data;
  // A dropped push sets OVF even when a clear arrives on the same edge.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cycle <= '0;
      ovf <= 1'b0;
    end else begin
      cycle <= wr_cycle ? bus.data : cycle + 32'd1;
      ovf <= (push & full & ~pop) | (ovf & ~clr);
    end
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf;
    status[ST_COUNT +: CW] = count;
  end
  assign bus.q_dmem = in_ram ? ram[bus.address_dmem[ADDR_WIDTH-1:0]] :
                      ~in_mmio ? '0 :
                      (off[1:0] == OFF_CYCLE) ? cycle :
                      (off[1:0] == OFF_STATUS) ? status : '0;
  dmem_responder_tx_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(bus.data),
    .dout(bus.tx_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule
